// File: rtl/mul8x8_seq_ctrl_pkg.sv
// mul_ctrl_pkg: state encoding, nibble-select and shift constants for the sequential 8x8 multiplier.
package mul_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
  localparam int PROD_W = 16;
  localparam int A_SEL_BIT = 1;
  localparam int B_SEL_BIT = 0;
  function automatic logic [3:0] step_shift(input logic [1:0] s);
    return (&s) ? 4'd8 : (^s) ? 4'd4 : 4'd0;
  endfunction
endpackage

// File: rtl/mul8x8_seq_ctrl_if.sv
// mul8x8_seq_ctrl_if: operand and result valid/ready handshakes.
interface mul8x8_seq_ctrl_if;
  import mul_ctrl_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic out_valid;
  logic out_ready;
  logic [PROD_W-1:0] out_p;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_p);
  modport slave (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_p);
endinterface

// File: rtl/array4x4multipler.sv
// array4x4multipler: combinational unsigned 4x4 array multiplier.
module array4x4multipler (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb
    p = {4'b0, a & {4{b[0]}}} + {3'b0, a & {4{b[1]}}, 1'b0}
      + {2'b0, a & {4{b[2]}}, 2'b0} + {1'b0, a & {4{b[3]}}, 3'b0};
endmodule

// File: rtl/mul8x8_seq_ctrl.sv
// mul8x8_seq_ctrl: 8x8 unsigned multiply over four nibble products on one shared 4x4 multiplier.
module mul8x8_seq_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int SKIP_ZERO = 0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  mul8x8_seq_ctrl_if.slave bus,
  output logic busy,
  output logic [CNT_W-1:0] op_count
);
  state_t state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [7:0] a_q, a_d, b_q, b_d, mp;
  logic [3:0] na, nb;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic zero_op;
  array4x4multipler u_mul (.a(na), .b(nb), .p(mp));
  always_comb begin
    na = step_q[A_SEL_BIT] ? a_q[7:4] : a_q[3:0];
    nb = step_q[B_SEL_BIT] ? b_q[7:4] : b_q[3:0];
    zero_op = (SKIP_ZERO != 0) && (bus.in_a == 8'd0 || bus.in_b == 8'd0);
    state_d = state_q;
    step_d = step_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d = bus.in_a;
        b_d = bus.in_b;
        acc_d = '0;
        // a zero operand runs only the final step, whose product is 0
        step_d = zero_op ? 2'd3 : 2'd0;
        state_d = MUL;
      end
      MUL: begin
        acc_d = acc_q + (PROD_W'(mp) << step_shift(step_q));
        step_d = step_q + 2'd1;
        state_d = (step_q == 2'd3) ? DONE : MUL;
      end
      DONE: if (bus.out_ready) begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  assign bus.in_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_p = acc_q;
  assign busy = (state_q == MUL) || (state_q == DONE);
  assign op_count = cnt_q;
endmodule
